reg_read_stage: RTL and testbench
=================================

// Module: reg_read_stage
// PURPOSE
//  Decode/register-read pipeline stage feeding reg_file. Splits a 32-bit RV64 instruction into
//  rs1/rs2/rd/opcode/funct fields and drives reg_file read addresses. Captures both operands and a
//  sign-extended immediate into one output pipeline register under valid/ready handshake.
//  Forwards same-cycle writeback data, because reg_file write lands only on the clock edge.
// PARAMETERS
//  REG_DATA_WIDTH_POW  6  log2 of operand width (data width = 64)
//  REG_MEM_DEPTH_POW   5  log2 of register count (32 registers, 5-bit indices)
// PORTS
//  clk_in            in   1   single clock, all state on posedge
//  rst_in            in   1   synchronous reset, active-high
//  flush_in          in   1   drop held and incoming instruction
//  instr_valid_in    in   1   upstream instruction valid
//  instr_ready_out   out  1   stage can accept instruction this cycle
//  instr_in          in   32  instruction word
//  rf_rs1_out        in/out: out 5  to reg_file rs1_in (= instr_in[19:15], combinational)
//  rf_rs2_out        out  5   to reg_file rs2_in (= instr_in[24:20], combinational)
//  rf_data1_in       in   64  from reg_file reg_data1_out (combinational read)
//  rf_data2_in       in   64  from reg_file reg_data2_out
//  wb_en_in          in   1   writeback strobe (same signal driving reg_file write_en)
//  wb_rd_in          in   5   writeback index (reg_file rd_in)
//  wb_data_in        in   64  writeback data (reg_file data_write)
//  out_valid_out     out  1   output register holds a valid instruction
//  out_ready_in      in   1   downstream accepts
//  out_rs1_data_out  out  64  operand 1
//  out_rs2_data_out  out  64  operand 2
//  out_imm_out       out  64  sign-extended immediate
//  out_rd_out        out  5   destination index
//  out_opcode_out    out  7   instr[6:0]
//  out_funct3_out    out  3   instr[14:12]
//  out_funct7_out    out  7   instr[31:25]
// BEHAVIOUR
//  Reset: every out_* register and out_valid_out = 0; instr_ready_out = 1 one cycle after reset.
//  instr_ready_out = !out_valid_out || out_ready_in (combinational, single-entry register).
//  Accept on instr_valid_in && instr_ready_out: all out_* loaded next edge, out_valid_out = 1;
//    latency one cycle. Downstream fire (out_valid && out_ready_in) without accept -> valid = 0.
//  Operand select per source (rsN = field index):
//    rsN == 0 -> 0; else wb_en_in && wb_rd_in == rsN -> wb_data_in; else rf_dataN_in.
//  Held refresh: while out_valid_out && !out_ready_in, a writeback with wb_en_in and wb_rd_in != 0
//    matching the held rs1 (rs2) index overwrites the held operand. Held rs1/rs2 indices are
//    stored internally for this. A write to x0 never forwards.
//  Immediate by opcode:
//    I (0010011, 0000011, 1100111, 0011011) sext(instr[31:20]);
//    S (0100011) sext({[31:25],[11:7]});
//    B (1100011) sext({[31],[7],[30:25],[11:8],0});
//    U (0110111, 0010111) sext({[31:12],12'b0});
//    J (1101111) sext({[31],[19:12],[20],[30:21],0}); any other opcode (R-type etc.) -> 0.
//  flush_in: next edge out_valid_out = 0 and the incoming instruction is not captured; flush
//    wins over accept. Data fields may keep stale values.
//  rst_in mid-transfer: rst_in wins over flush and accept; the held instruction is lost.
//  instr_valid_in low: out_* data fields hold their values; only out_valid_out changes.
// TESTING
//  1 Reset then idle: rst_in high 2 cycles -> out_valid_out=0, all out_* = 0, instr_ready_out=1.
//  2 rf_data1_in=64'h1234 for x5, addi x7,x5,-1 (0xFFF28393) -> next cycle rs1_data=64'h1234,
//    imm=64'hFFFF_FFFF_FFFF_FFFF, rd=7, opcode=0010011.
//  3 Same instr with wb_en_in=1, wb_rd_in=5, wb_data_in=64'hAA in accept cycle -> rs1_data=64'hAA.
//    With wb_rd_in=0 -> no forward.
//  4 Stall: out_ready_in=0 holding add x3,x1,x2; wb writes x2=64'h55 -> out_rs2_data_out
//    becomes 64'h55 next cycle. instr_ready_out=0 throughout; the new instr is not taken.
//  5 Source x0: rs1=0 with rf_data1_in=64'hDEAD and wb_rd_in=0 -> rs1_data=0.
//  6 flush_in with instr_valid_in=1 and out_valid_out=1 -> out_valid_out=0 next cycle.
//    rst_in during stall -> out_valid_out=0, outputs zero.

Source files
------------

// File: rtl/reg_read_stage.sv
// rtl/reg_read_stage.sv - decode/register-read stage with writeback forwarding and held-operand refresh
module reg_read_stage #(
    parameter int REG_DATA_WIDTH_POW = 6,
    parameter int REG_MEM_DEPTH_POW  = 5
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                flush_in,
    input  logic                                instr_valid_in,
    output logic                                instr_ready_out,
    input  logic [31:0]                         instr_in,
    output logic [REG_MEM_DEPTH_POW-1:0]        rf_rs1_out,
    output logic [REG_MEM_DEPTH_POW-1:0]        rf_rs2_out,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]  rf_data1_in,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]  rf_data2_in,
    input  logic                                wb_en_in,
    input  logic [REG_MEM_DEPTH_POW-1:0]        wb_rd_in,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]  wb_data_in,
    output logic                                out_valid_out,
    input  logic                                out_ready_in,
    output logic [(1<<REG_DATA_WIDTH_POW)-1:0]  out_rs1_data_out,
    output logic [(1<<REG_DATA_WIDTH_POW)-1:0]  out_rs2_data_out,
    output logic [(1<<REG_DATA_WIDTH_POW)-1:0]  out_imm_out,
    output logic [REG_MEM_DEPTH_POW-1:0]        out_rd_out,
    output logic [6:0]                          out_opcode_out,
    output logic [2:0]                          out_funct3_out,
    output logic [6:0]                          out_funct7_out
);

    localparam int DW = 1 << REG_DATA_WIDTH_POW;
    localparam int AW = REG_MEM_DEPTH_POW;

    logic          valid_q, valid_d;
    logic [DW-1:0] rs1_data_q, rs1_data_d;
    logic [DW-1:0] rs2_data_q, rs2_data_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [6:0]    opcode_q, opcode_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [6:0]    funct7_q, funct7_d;
    logic [AW-1:0] held_rs1_q, held_rs1_d;
    logic [AW-1:0] held_rs2_q, held_rs2_d;

    logic [AW-1:0] rs1_idx, rs2_idx;
    logic [6:0]    opcode;
    logic [DW-1:0] op1, op2, imm;
    logic          accept, stalled, wb_live;

    assign rs1_idx         = instr_in[15 +: AW];
    assign rs2_idx         = instr_in[20 +: AW];
    assign opcode          = instr_in[6:0];
    assign rf_rs1_out      = rs1_idx;
    assign rf_rs2_out      = rs2_idx;
    assign instr_ready_out = !valid_q || out_ready_in;
    assign accept          = instr_valid_in && instr_ready_out;
    assign stalled         = valid_q && !out_ready_in;
    // x0 is hardwired zero, so a writeback to it must never be forwarded
    assign wb_live         = wb_en_in && (wb_rd_in != '0);

    always_comb begin
        op1 = rf_data1_in;
        if (rs1_idx == '0)
            op1 = '0;
        else if (wb_live && wb_rd_in == rs1_idx)
            op1 = wb_data_in;
        op2 = rf_data2_in;
        if (rs2_idx == '0)
            op2 = '0;
        else if (wb_live && wb_rd_in == rs2_idx)
            op2 = wb_data_in;
    end

    always_comb begin
        imm = '0;
        case (opcode)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011:
                imm = {{(DW-12){instr_in[31]}}, instr_in[31:20]};
            7'b0100011:
                imm = {{(DW-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            7'b1100011:
                imm = {{(DW-13){instr_in[31]}}, instr_in[31], instr_in[7],
                       instr_in[30:25], instr_in[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm = {{(DW-32){instr_in[31]}}, instr_in[31:12], 12'b0};
            7'b1101111:
                imm = {{(DW-21){instr_in[31]}}, instr_in[31], instr_in[19:12],
                       instr_in[20], instr_in[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

    always_comb begin
        valid_d    = valid_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rd_d       = rd_q;
        opcode_d   = opcode_q;
        funct3_d   = funct3_q;
        funct7_d   = funct7_q;
        held_rs1_d = held_rs1_q;
        held_rs2_d = held_rs2_q;

        if (flush_in)
            valid_d = 1'b0;
        else if (accept)
            valid_d = 1'b1;
        else if (valid_q && out_ready_in)
            valid_d = 1'b0;

        if (accept && !flush_in) begin
            rs1_data_d = op1;
            rs2_data_d = op2;
            imm_d      = imm;
            rd_d       = instr_in[7 +: AW];
            opcode_d   = opcode;
            funct3_d   = instr_in[14:12];
            funct7_d   = instr_in[31:25];
            held_rs1_d = rs1_idx;
            held_rs2_d = rs2_idx;
        end else if (stalled && wb_live) begin
            // reg_file is written this edge; keep the held operands coherent with it
            if (wb_rd_in == held_rs1_q)
                rs1_data_d = wb_data_in;
            if (wb_rd_in == held_rs2_q)
                rs2_data_d = wb_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q    <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
            opcode_q   <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            held_rs1_q <= '0;
            held_rs2_q <= '0;
        end else begin
            valid_q    <= valid_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            opcode_q   <= opcode_d;
            funct3_q   <= funct3_d;
            funct7_q   <= funct7_d;
            held_rs1_q <= held_rs1_d;
            held_rs2_q <= held_rs2_d;
        end
    end

    assign out_valid_out    = valid_q;
    assign out_rs1_data_out = rs1_data_q;
    assign out_rs2_data_out = rs2_data_q;
    assign out_imm_out      = imm_q;
    assign out_rd_out       = rd_q;
    assign out_opcode_out   = opcode_q;
    assign out_funct3_out   = funct3_q;
    assign out_funct7_out   = funct7_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// tb/tb_reg_read_stage.sv - self-checking bench for reg_read_stage against a behavioural model
module tb_reg_read_stage;

    logic        clk_in = 1'b0;
    logic        rst_in, flush_in, instr_valid_in, instr_ready_out;
    logic [31:0] instr_in;
    logic [4:0]  rf_rs1_out, rf_rs2_out;
    logic [63:0] rf_data1_in, rf_data2_in;
    logic        wb_en_in;
    logic [4:0]  wb_rd_in;
    logic [63:0] wb_data_in;
    logic        out_valid_out, out_ready_in;
    logic [63:0] out_rs1_data_out, out_rs2_data_out, out_imm_out;
    logic [4:0]  out_rd_out;
    logic [6:0]  out_opcode_out, out_funct7_out;
    logic [2:0]  out_funct3_out;

    int errors = 0;
    int checks = 0;

    // model state
    logic        m_known = 1'b0;
    logic        m_valid = 1'b0;
    logic [63:0] m_d1 = '0, m_d2 = '0, m_imm = '0;
    logic [4:0]  m_rd = '0, m_h1 = '0, m_h2 = '0;
    logic [6:0]  m_op = '0, m_f7 = '0;
    logic [2:0]  m_f3 = '0;

    reg_read_stage dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
        .instr_in(instr_in), .rf_rs1_out(rf_rs1_out), .rf_rs2_out(rf_rs2_out),
        .rf_data1_in(rf_data1_in), .rf_data2_in(rf_data2_in),
        .wb_en_in(wb_en_in), .wb_rd_in(wb_rd_in), .wb_data_in(wb_data_in),
        .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
        .out_rs1_data_out(out_rs1_data_out), .out_rs2_data_out(out_rs2_data_out),
        .out_imm_out(out_imm_out), .out_rd_out(out_rd_out),
        .out_opcode_out(out_opcode_out), .out_funct3_out(out_funct3_out),
        .out_funct7_out(out_funct7_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_imm(input logic [31:0] i);
        longint v;
        v = 0;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h1B: v = $signed(i[31:20]);
            7'h23: v = $signed({i[31:25], i[11:7]});
            7'h63: v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
            7'h37, 7'h17: v = $signed(i[31:12]) * 4096;
            7'h6F: v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [63:0] ref_operand(input logic [4:0] idx, input logic [63:0] rf);
        if (idx == 0) return 64'h0;
        if (wb_en_in && wb_rd_in == idx) return wb_data_in;
        return rf;
    endfunction

    // one clock: inputs already applied after a negedge; outputs compared at the next negedge
    task automatic cycle();
        logic        acc, n_valid;
        logic [63:0] n_d1, n_d2, n_imm;
        logic [4:0]  n_rd, n_h1, n_h2;
        logic [6:0]  n_op, n_f7;
        logic [2:0]  n_f3;
        #1;
        if (m_known)
            check("ready", {63'b0, instr_ready_out}, {63'b0, !m_valid || out_ready_in});
        check("rs1_addr", {59'b0, rf_rs1_out}, {59'b0, instr_in[19:15]});
        check("rs2_addr", {59'b0, rf_rs2_out}, {59'b0, instr_in[24:20]});
        acc = instr_valid_in && (!m_valid || out_ready_in);
        n_valid = m_valid; n_d1 = m_d1; n_d2 = m_d2; n_imm = m_imm; n_rd = m_rd;
        n_op = m_op; n_f3 = m_f3; n_f7 = m_f7; n_h1 = m_h1; n_h2 = m_h2;
        if (rst_in) begin
            n_valid = 0; n_d1 = 0; n_d2 = 0; n_imm = 0; n_rd = 0;
            n_op = 0; n_f3 = 0; n_f7 = 0; n_h1 = 0; n_h2 = 0;
        end else begin
            if (flush_in) n_valid = 0;
            else if (acc) n_valid = 1;
            else if (m_valid && out_ready_in) n_valid = 0;
            if (acc && !flush_in) begin
                n_d1 = ref_operand(instr_in[19:15], rf_data1_in);
                n_d2 = ref_operand(instr_in[24:20], rf_data2_in);
                n_imm = ref_imm(instr_in);
                n_rd = instr_in[11:7]; n_op = instr_in[6:0];
                n_f3 = instr_in[14:12]; n_f7 = instr_in[31:25];
                n_h1 = instr_in[19:15]; n_h2 = instr_in[24:20];
            end else if (m_valid && !out_ready_in && wb_en_in && wb_rd_in != 0) begin
                if (wb_rd_in == m_h1) n_d1 = wb_data_in;
                if (wb_rd_in == m_h2) n_d2 = wb_data_in;
            end
        end
        if (rst_in) m_known = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        m_valid = n_valid; m_d1 = n_d1; m_d2 = n_d2; m_imm = n_imm; m_rd = n_rd;
        m_op = n_op; m_f3 = n_f3; m_f7 = n_f7; m_h1 = n_h1; m_h2 = n_h2;
        if (m_known) begin
            check("valid", {63'b0, out_valid_out}, {63'b0, m_valid});
            if (m_valid) begin
                check("rs1_data", out_rs1_data_out, m_d1);
                check("rs2_data", out_rs2_data_out, m_d2);
                check("imm", out_imm_out, m_imm);
                check("rd", {59'b0, out_rd_out}, {59'b0, m_rd});
                check("opcode", {57'b0, out_opcode_out}, {57'b0, m_op});
                check("funct3", {61'b0, out_funct3_out}, {61'b0, m_f3});
                check("funct7", {57'b0, out_funct7_out}, {57'b0, m_f7});
            end
        end
    endtask

    task automatic idle();
        rst_in = 0; flush_in = 0; instr_valid_in = 0; instr_in = 32'h0000_0013;
        rf_data1_in = 0; rf_data2_in = 0; wb_en_in = 0; wb_rd_in = 0; wb_data_in = 0;
        out_ready_in = 1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rs1"}, out_rs1_data_out, 64'h0);
        check({tag, "_rs2"}, out_rs2_data_out, 64'h0);
        check({tag, "_imm"}, out_imm_out, 64'h0);
        check({tag, "_fields"}, {42'b0, out_rd_out, out_opcode_out, out_funct3_out, out_funct7_out}, 64'h0);
    endtask

    logic [6:0] ops [12];

    initial begin
        ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F};
        idle();
        rst_in = 1;
        @(negedge clk_in);
        // reset then idle
        cycle(); cycle();
        idle();
        check("rst_valid", {63'b0, out_valid_out}, 64'h0);
        check_zero("rst");
        cycle();
        check("rst_ready", {63'b0, instr_ready_out}, 64'h1);

        // addi x7,x5,-1 with x5 = 0x1234
        instr_valid_in = 1; instr_in = 32'hFFF28393; rf_data1_in = 64'h1234;
        cycle();
        check("addi_rs1", out_rs1_data_out, 64'h1234);
        check("addi_imm", out_imm_out, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_rd", {59'b0, out_rd_out}, 64'd7);
        check("addi_op", {57'b0, out_opcode_out}, 64'h13);

        // same-cycle writeback forward, then a write to x0 that must not forward
        wb_en_in = 1; wb_rd_in = 5; wb_data_in = 64'hAA;
        cycle();
        check("fwd_rs1", out_rs1_data_out, 64'hAA);
        wb_rd_in = 0;
        cycle();
        check("nofwd_rs1", out_rs1_data_out, 64'h1234);

        // stall holding add x3,x1,x2 while x2 is written
        idle();
        instr_valid_in = 1; instr_in = 32'h002081B3; rf_data1_in = 64'h11; rf_data2_in = 64'h22;
        cycle();
        out_ready_in = 0; instr_in = 32'h00A00093;
        wb_en_in = 1; wb_rd_in = 2; wb_data_in = 64'h55;
        cycle();
        check("stall_rs2", out_rs2_data_out, 64'h55);
        check("stall_rs1", out_rs1_data_out, 64'h11);
        check("stall_op", {57'b0, out_opcode_out}, 64'h33);
        wb_en_in = 0;
        cycle();
        check("stall_ready", {63'b0, instr_ready_out}, 64'h0);
        check("stall_rd", {59'b0, out_rd_out}, 64'd3);

        // reset during stall
        rst_in = 1;
        cycle();
        rst_in = 0;
        check("rststall_valid", {63'b0, out_valid_out}, 64'h0);
        check_zero("rststall");

        // x0 source reads zero regardless of rf and writeback
        idle();
        instr_valid_in = 1; instr_in = 32'hFFF00393; rf_data1_in = 64'hDEAD;
        wb_en_in = 1; wb_rd_in = 0; wb_data_in = 64'hBEEF;
        cycle();
        check("x0_rs1", out_rs1_data_out, 64'h0);

        // flush beats accept
        out_ready_in = 1; flush_in = 1; instr_in = 32'h00500113;
        cycle();
        check("flush_valid", {63'b0, out_valid_out}, 64'h0);
        flush_in = 0;

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r;
            r = $urandom;
            r[6:0]   = ops[$urandom_range(0, 11)];
            r[19:15] = 5'($urandom_range(0, 3));
            r[24:20] = 5'($urandom_range(0, 3));
            rst_in         = ($urandom_range(0, 99) == 0);
            flush_in       = ($urandom_range(0, 19) == 0);
            instr_valid_in = ($urandom_range(0, 3) != 0);
            out_ready_in   = ($urandom_range(0, 2) != 0);
            instr_in       = r;
            rf_data1_in    = {$urandom, $urandom};
            rf_data2_in    = {$urandom, $urandom};
            wb_en_in       = $urandom_range(0, 1) == 1;
            wb_rd_in       = 5'($urandom_range(0, 3));
            wb_data_in     = {$urandom, $urandom};
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
